// File: rtl/mainmemory_pipe.sv
// Parametrised line-wide main memory with valid/ready requests and in-order read pipeline.
// Optional MAINMEM_PIPE_STATS_EN adds saturating read/write/error counters.
module mainmemory_pipe #(
  parameter int DATA_W     = 256,
  parameter int ENTRIES    = 256,
  parameter int ADDR_W     = 32,
  parameter int READ_LAT   = 2,
  parameter int WRITE_TPUT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wd,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rd,
  output logic                rsp_err
`ifdef MAINMEM_PIPE_STATS_EN
  ,
  output logic [31:0]         stat_rd,
  output logic [31:0]         stat_wr,
  output logic [15:0]         stat_err
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = 4;

  logic [DATA_W-1:0] mem_q [ENTRIES];

  logic [CNT_W-1:0]  busy_q;
  logic [CNT_W-1:0]  busy_d;

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] err_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  logic              in_rng;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = (busy_q == '0);
  assign acc       = req_valid & req_ready & rst_n;
  assign wr_acc    = acc & req_write;
  assign rd_acc    = acc & ~req_write;
  assign in_rng    = {1'b0, req_addr} < (ADDR_W+1)'(ENTRIES);
  assign idx       = req_addr[IDX_W-1:0];
  assign rd_data   = in_rng ? mem_q[idx] : '0;

  always_comb begin
    busy_d = busy_q;
    if (wr_acc)
      busy_d = CNT_W'(WRITE_TPUT - 1);
    else if (busy_q != '0)
      busy_d = busy_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // Array is deliberately not reset; writes committed before reset persist.
  always_ff @(posedge clk) begin
    if (wr_acc && in_rng) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_be[i])
          mem_q[idx][8*i +: 8] <= req_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LAT; i++)
        dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      err_q[0] <= rd_acc & ~in_rng;
      dat_q[0] <= rd_acc ? rd_data : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[READ_LAT-1];
  assign rsp_err   = err_q[READ_LAT-1];
  assign rsp_rd    = dat_q[READ_LAT-1];

`ifdef MAINMEM_PIPE_STATS_EN
  logic [31:0] st_rd_q;
  logic [31:0] st_wr_q;
  logic [15:0] st_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_rd_q  <= '0;
      st_wr_q  <= '0;
      st_err_q <= '0;
    end else begin
      if (rd_acc && (st_rd_q != '1))
        st_rd_q <= st_rd_q + 32'd1;
      if (wr_acc && (st_wr_q != '1))
        st_wr_q <= st_wr_q + 32'd1;
      if (acc && !in_rng && (st_err_q != '1))
        st_err_q <= st_err_q + 16'd1;
    end
  end

  assign stat_rd  = st_rd_q;
  assign stat_wr  = st_wr_q;
  assign stat_err = st_err_q;
`endif

endmodule

// File: tb/tb_mainmemory_pipe.sv
// Scoreboard bench for mainmemory_pipe: directed requests, decoupled response monitor.
// Runs with READ_LAT=4, WRITE_TPUT=4 to exercise stalls and reset flush.
module tb_mainmemory_pipe;

  localparam int DW = 256;
  localparam int N  = 256;
  localparam int AW = 32;
  localparam int RL = 4;
  localparam int WT = 4;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [NB-1:0] req_be = '0;
  logic [DW-1:0] req_wd = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rd;
`ifdef MAINMEM_PIPE_STATS_EN
  logic [31:0]   stat_rd;
  logic [31:0]   stat_wr;
  logic [15:0]   stat_err;
`endif

  mainmemory_pipe #(
    .DATA_W(DW), .ENTRIES(N), .ADDR_W(AW),
    .READ_LAT(RL), .WRITE_TPUT(WT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_be(req_be), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err)
`ifdef MAINMEM_PIPE_STATS_EN
    ,
    .stat_rd(stat_rd), .stat_wr(stat_wr),
    .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [DW-1:0] d;
    bit            known;
    int            cyc;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mdl [N];
  bit            kn  [N];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkpat(input int seed);
    logic [DW-1:0] p;
    for (int i = 0; i < NB; i++)
      p[8*i +: 8] = 8'(seed * 37 + i * 5);
    return p;
  endfunction

  // Monitor: pops one expectation per response, checks data, error and timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 at cyc %0d want none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("rsp_cyc", cyc, e.cyc);
          chk("rsp_err", rsp_err, e.err);
          if (e.known) chk("rsp_rd", rsp_rd, e.d);
        end
      end else begin
        chk("rsp_idle_rd", rsp_rd, '0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit w, input logic [AW-1:0] a,
                       input logic [NB-1:0] be, input logic [DW-1:0] wd,
                       output int stall);
    exp_t e;
    int   ia;
    stall = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_be    = be;
    req_wd    = wd;
    while (!req_ready && stall < 20) begin
      @(negedge clk);
      stall++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles want accept", stall);
      req_valid = 1'b0;
      return;
    end
    ia = int'(a);
    if (w) begin
      n_wr++;
      if (a < N) begin
        for (int i = 0; i < NB; i++)
          if (be[i]) mdl[ia][8*i +: 8] = wd[8*i +: 8];
        kn[ia] = kn[ia] | (&be);
      end else begin
        n_err++;
      end
    end else begin
      n_rd++;
      e.cyc = cyc + RL;
      if (a < N) begin
        e.err = 1'b0;
        e.d = mdl[ia];
        e.known = kn[ia];
      end else begin
        e.err = 1'b1;
        e.d = '0;
        e.known = 1'b1;
        n_err++;
      end
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    req_valid = 1'b0;
    while (sbq.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  task automatic chk_stats(input string nm);
`ifdef MAINMEM_PIPE_STATS_EN
    chk({nm, "_stat_rd"}, stat_rd, n_rd);
    chk({nm, "_stat_wr"}, stat_wr, n_wr);
    chk({nm, "_stat_err"}, stat_err, n_err);
`else
    chk({nm, "_ready"}, req_ready, 1'b1);
`endif
  endtask

  initial begin
    int st;
    logic [DW-1:0] aa;
    for (int i = 0; i < N; i++) kn[i] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_rd", rsp_rd, '0);
    rst_n = 1'b1;
    chk("rst_ready", req_ready, 1'b1);
    chk_stats("rst");
    @(negedge clk);

    issue(1'b0, 32'd5, '0, '0, st);
    chk("rd5_stall", st, 0);
    chk("rd5_ready", req_ready, 1'b1);
    idle(RL + 2);

    issue(1'b1, 32'd3, '1, mkpat(0), st);
    issue(1'b0, 32'd3, '0, '0, st);
    chk("raw_stall", st, WT - 1);
    idle(RL + 2);

    aa = {NB{8'hAA}};
    issue(1'b1, 32'd3, 32'h0000_000F, aa, st);
    issue(1'b0, 32'd3, '0, '0, st);
    idle(RL + 2);

    issue(1'b1, 32'd1, '1, mkpat(1), st);
    issue(1'b1, 32'd2, '1, mkpat(2), st);
    chk("wr_stall", st, WT - 1);
    issue(1'b1, 32'd0, '1, mkpat(3), st);
    issue(1'b1, 32'd44, '1, mkpat(4), st);
    issue(1'b1, 32'd13, '1, mkpat(5), st);
    issue(1'b1, 32'd300, '1, mkpat(6), st);
    idle(WT);

    issue(1'b0, 32'd0, '0, '0, st);
    chk("b2b_stall0", st, 0);
    issue(1'b0, 32'd1, '0, '0, st);
    chk("b2b_stall1", st, 0);
    issue(1'b0, 32'd300, '0, '0, st);
    chk("b2b_stall2", st, 0);
    issue(1'b0, 32'd2, '0, '0, st);
    chk("b2b_stall3", st, 0);
    issue(1'b0, 32'd44, '0, '0, st);
    drain();
    chk_stats("mid");

    issue(1'b0, 32'd10, '0, '0, st);
    issue(1'b0, 32'd11, '0, '0, st);
    issue(1'b1, 32'd12, '1, mkpat(7), st);
    chk("wr_after_rd_stall", st, 0);
    rst_n = 1'b0;
    sbq.delete();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd13;
    req_be    = '1;
    req_wd    = ~mkpat(5);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    chk("rst2_ready", req_ready, 1'b1);
    n_rd = 0;
    n_wr = 0;
    n_err = 0;
    chk_stats("rst2");
    idle(RL + 3);

    issue(1'b0, 32'd12, '0, '0, st);
    issue(1'b0, 32'd13, '0, '0, st);
    drain();
    chk_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mainmemory_pipe.md
Name: mainmemory_pipe

Overview:
Parametrised main-memory model with a valid/ready request port and an in-order read-response pipeline.
- Replaces the fixed 256-bit, fixed-latency memory model behind the L1 cache fill/writeback path.
- Generalises line width, depth, read latency and write throughput.
- Adds backpressure, out-of-range error reporting and correct read-after-write ordering.

Parameters:
DATA_W, 256, line width in bits; must be a multiple of 8
ENTRIES, 256, number of lines
ADDR_W, 32, request address width (line index, not byte address)
READ_LAT, 2, cycles from read acceptance to rsp_valid; legal range 1..8
WRITE_TPUT, 2, minimum cycles between an accepted write and the next accepted request; legal range 1..8

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  model can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  line index
req_be  in  DATA_W/8  byte enables (writes only)
req_wd  in  DATA_W  write data
rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
rsp_rd  out  DATA_W  read data
rsp_err  out  1  qualifies rsp_valid: address was >= ENTRIES

Behaviour:
- Accept condition: req_valid & req_ready at posedge. One request per cycle maximum.
- Write, in range:
  - Bytes with req_be[i]=1 take req_wd[8i+7:8i] at the accepting edge.
  - Bytes with req_be[i]=0 are unchanged.
  - be all-zero is a legal no-op that still consumes throughput.
- Write, out of range: dropped silently. No response is generated.
- Write throughput: after an accepted write, req_ready=0 for WRITE_TPUT-1 cycles.
  - Implemented with a busy down-counter.
  - WRITE_TPUT=1 gives no stall.
- Reads never stall: req_ready stays 1 across back-to-back reads.
- Read data is sampled from the array at the accepting edge.
  - A read accepted the cycle after a write to the same line returns the new data.
- Read pipeline:
  - READ_LAT-stage shift register of {valid, err, data}.
  - rsp_valid, rsp_rd and rsp_err are driven from the last stage.
  - Responses are strictly in order, so back-to-back reads produce back-to-back responses.
- Out-of-range read: the response still appears after READ_LAT cycles, with rsp_err=1 and rsp_rd=0.
- rsp_rd is 0 whenever rsp_valid=0; it never holds stale data and never goes X.
- Reset (rst_n=0 sampled at posedge):
  - rsp_valid=0, rsp_err=0, rsp_rd=0.
  - All pipeline valid bits cleared; busy counter cleared.
  - req_ready=1 in the first cycle after rst_n rises.
  - Array contents are not reset.
- Reset mid-operation: in-flight reads are dropped with no response. A write accepted before reset stays committed.
- Requests presented while rst_n=0 are ignored.
- req_ready does not depend combinationally on req_valid.

Optional Feature:
MAINMEM_PIPE_STATS_EN
- Defined: adds outputs stat_rd (32 bits), stat_wr (32 bits) and stat_err (16 bits).
  - Count accepted reads, accepted writes and out-of-range requests respectively.
  - Cleared by rst_n; saturate at all-ones with no wrap.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then a read of addr 5 with defaults → rsp_valid exactly 2 cycles after acceptance, rsp_err=0, req_ready=1 throughout.
- Write addr 3 with wd = 256'h0102..20 and be=32'hFFFF_FFFF, then read addr 3 → rsp_rd equals the written pattern.
- Write addr 3 with be=32'h0000_000F and wd bytes 0xAA, then read → bytes 0-3 are 0xAA and bytes 4-31 keep their prior values.
- WRITE_TPUT=4 with back-to-back writes to addr 1 and 2 under req_valid held high → req_ready low for 3 cycles between acceptances; stat_wr=2 with the macro defined.
- Four consecutive reads of addr 0,1,300,2 with ENTRIES=256 → four consecutive rsp_valid pulses in order; the third has rsp_err=1 and rsp_rd=0.
- READ_LAT=4 with two reads accepted, then rst_n=0 for 1 cycle → no rsp_valid afterwards; req_ready=1 in the cycle after rst_n rises.
